pc_control: RTL and testbench

PC_CONTROL -- requirements
Module: pc_control

---
 rtl/pc_control.sv | 135 +++++++++++++
 tb/tb_pc_control.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_control.sv
// rtl/pc_control.sv - program counter with conditional jump/call/ret and optional return stack
// Return stack, call/ret and the overflow/underflow flags exist only when PC_CALL_STACK_EN is defined.
module pc_control #(
  parameter int unsigned          ADDR_SIZE   = 16,
  parameter int unsigned          STACK_DEPTH = 8,
  parameter logic [ADDR_SIZE-1:0] RESET_ADDR  = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 if_ok,
  input  logic                 jump,
  input  logic                 call,
  input  logic                 ret,
  input  logic [ADDR_SIZE-1:0] target,
  output logic [ADDR_SIZE-1:0] pc,
  output logic                 taken,
  output logic                 stack_overflow,
  output logic                 stack_underflow
);

  logic [ADDR_SIZE-1:0] r_pc;
  logic                 r_taken;
  logic [ADDR_SIZE-1:0] w_pc_inc;
  logic [ADDR_SIZE-1:0] w_next_pc;
  logic                 w_taken;

  assign w_pc_inc = r_pc + ADDR_SIZE'(1);
  assign pc       = r_pc;
  assign taken    = r_taken;

`ifdef PC_CALL_STACK_EN
  localparam int unsigned     SP_W    = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned     IX_W    = SP_W - 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_SIZE-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]      r_sp;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ovf;
  logic                 w_unf;
  logic [IX_W-1:0]      w_wr_idx;
  logic [IX_W-1:0]      w_rd_idx;

  // r_sp counts entries; slot r_sp holds the next push, slot r_sp-1 is the top.
  assign w_full          = (r_sp == SP_FULL);
  assign w_empty         = (r_sp == '0);
  assign w_wr_idx        = r_sp[IX_W-1:0];
  assign w_rd_idx        = w_wr_idx - IX_W'(1);
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

  always_comb begin
    w_next_pc = w_pc_inc;
    w_taken   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    if (ret) begin
      if (if_ok) begin
        if (w_empty) begin
          w_unf = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_next_pc = r_stack[w_rd_idx];
          w_taken   = 1'b1;
        end
      end
    end else if (call) begin
      if (if_ok) begin
        w_next_pc = target;
        w_taken   = 1'b1;
        if (w_full) w_ovf = 1'b1;
        else        w_push = 1'b1;
      end
    end else if (jump && if_ok) begin
      w_next_pc = target;
      w_taken   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (enable) begin
      if (w_push)     r_sp <= r_sp + SP_W'(1);
      else if (w_pop) r_sp <= r_sp - SP_W'(1);
      r_ovf <= r_ovf | w_ovf;
      r_unf <= r_unf | w_unf;
    end
  end

  // Entry storage is not reset; a write is suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n && enable && w_push) r_stack[w_wr_idx] <= w_pc_inc;
  end
`else
  logic w_unused_depth;

  assign w_unused_depth  = (STACK_DEPTH > 1);
  assign stack_overflow  = 1'b0;
  assign stack_underflow = 1'b0;

  // Without a stack, call degenerates to jump and ret still wins priority but only advances.
  always_comb begin
    w_next_pc = w_pc_inc;
    w_taken   = 1'b0;
    if (!ret && (call || jump) && if_ok) begin
      w_next_pc = target;
      w_taken   = 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_ADDR;
      r_taken <= 1'b0;
    end else if (enable) begin
      r_pc    <= w_next_pc;
      r_taken <= w_taken;
    end else begin
      r_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// tb/tb_pc_control.sv - scoreboard bench for pc_control (expectations follow PC_CALL_STACK_EN)
module tb_pc_control;
  localparam int AW = 16;
`ifdef PC_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable  = 1'b0;
  logic          if_ok   = 1'b0;
  logic          jump    = 1'b0;
  logic          call    = 1'b0;
  logic          ret     = 1'b0;
  logic [AW-1:0] target  = '0;
  logic [AW-1:0] pc;
  logic          taken;
  logic          stack_overflow;
  logic          stack_underflow;

  typedef struct {
    string         name;
    logic [AW-1:0] pc;
    logic          taken;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic e_ovf = 1'b0;
  logic e_unf = 1'b0;

  always #5 clock = ~clock;

  pc_control #(.ADDR_SIZE(AW), .STACK_DEPTH(8), .RESET_ADDR(16'h0000)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .if_ok(if_ok),
    .jump(jump), .call(call), .ret(ret), .target(target), .pc(pc),
    .taken(taken), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      if ({pc, taken, stack_overflow, stack_underflow} !== {e.pc, e.taken, e.ovf, e.unf}) begin
        n_bad++;
        $display("FAIL %s: got pc=%h taken=%b ovf=%b unf=%b, want pc=%h taken=%b ovf=%b unf=%b",
                 e.name, pc, taken, stack_overflow, stack_underflow, e.pc, e.taken, e.ovf, e.unf);
      end
    end
  end

  task automatic expect_now(input string nm, input logic [AW-1:0] p, input logic t);
    exp_t e;
    e.name  = nm;
    e.pc    = p;
    e.taken = t;
    e.ovf   = e_ovf;
    e.unf   = e_unf;
    sb_q.push_back(e);
  endtask

  task automatic step(input string nm, input logic en, input logic j, input logic c,
                      input logic r, input logic ok, input logic [AW-1:0] tgt,
                      input logic [AW-1:0] p, input logic t);
    @(negedge clock);
    enable = en; jump = j; call = c; ret = r; if_ok = ok; target = tgt;
    @(posedge clock);
    #1;
    expect_now(nm, p, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] tg;
    logic [AW-1:0] ra;
    int            m;
    int            w;

    reset_n = 1'b0;
    @(posedge clock);
    #1;
    expect_now("reset", 16'h0000, 1'b0);
    @(negedge clock);
    #1 reset_n = 1'b1;

    step("seq1", 1, 0, 0, 0, 0, 16'h0, 16'h0001, 0);
    step("seq2", 1, 0, 0, 0, 0, 16'h0, 16'h0002, 0);
    step("seq3", 1, 0, 0, 0, 0, 16'h0, 16'h0003, 0);

    step("jmp_10",    1, 1, 0, 0, 1, 16'h0010, 16'h0010, 1);
    step("jmp_no",    1, 1, 0, 0, 0, 16'h0100, 16'h0011, 0);
    step("jmp_10b",   1, 1, 0, 0, 1, 16'h0010, 16'h0010, 1);
    step("jmp_100",   1, 1, 0, 0, 1, 16'h0100, 16'h0100, 1);
    step("hold_en0",  0, 1, 0, 0, 1, 16'h0300, 16'h0100, 0);

    step("jmp_5",     1, 1, 0, 0, 1, 16'h0005, 16'h0005, 1);
    step("call_200",  1, 0, 1, 0, 1, 16'h0200, 16'h0200, 1);
    step("seq_201",   1, 0, 0, 0, 0, 16'h0, 16'h0201, 0);
    step("seq_202",   1, 0, 0, 0, 0, 16'h0, 16'h0202, 0);
    step("ret_6",     1, 0, 0, 1, 1, 16'h0, STK ? 16'h0006 : 16'h0203, STK);
    step("call_no",   1, 0, 1, 0, 0, 16'h0400, STK ? 16'h0007 : 16'h0204, 0);
    step("ret_no",    1, 0, 0, 1, 0, 16'h0, STK ? 16'h0008 : 16'h0205, 0);

    step("jmp_1000",  1, 1, 0, 0, 1, 16'h1000, 16'h1000, 1);
    for (int k = 0; k < 9; k++) begin
      tg = 16'h2000 + 16'(k * 16);
      if (k == 8) e_ovf = STK;
      step($sformatf("call%0d", k), 1, 0, 1, 0, 1, tg, tg, 1);
    end
    for (int j = 0; j < 8; j++) begin
      m  = 7 - j;
      ra = (m == 0) ? 16'h1001 : 16'h2001 + 16'((m - 1) * 16);
      step($sformatf("ret%0d", j), 1, 0, 0, 1, 1, 16'h0,
           STK ? ra : 16'h2081 + 16'(j), STK);
    end
    e_unf = STK;
    step("ret_unf",   1, 0, 0, 1, 1, 16'h0, STK ? 16'h1002 : 16'h2089, 0);

    step("jmp_ffff",  1, 1, 0, 0, 1, 16'hFFFF, 16'hFFFF, 1);
    step("wrap",      1, 0, 0, 0, 0, 16'h0, 16'h0000, 0);
    step("call_3000", 1, 0, 1, 0, 1, 16'h3000, 16'h3000, 1);
    step("prio_all",  1, 1, 1, 1, 1, 16'h4000, STK ? 16'h0001 : 16'h3001, STK);
    step("hold2",     0, 1, 0, 0, 1, 16'h7777, STK ? 16'h0001 : 16'h3001, 0);

    @(negedge clock);
    enable = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; if_ok = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    e_ovf = 1'b0;
    e_unf = 1'b0;
    #1 expect_now("async_reset", 16'h0000, 1'b0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    step("first_after_rst", 1, 0, 0, 0, 0, 16'h0, 16'h0001, 0);
    step("jmp_after_rst",   1, 1, 0, 0, 1, 16'h0ABC, 16'h0ABC, 1);

    w = 0;
    while (sb_q.size() > 0 && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations pending, want 0", sb_q.size());
    end
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
